// File: rtl/cpu_bus_pkg.sv
// Shared types for the sram_like CPU bus: transfer sizes, arbiter states, owner encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_bus_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // free, picking a master every cycle
        ADDR = 2'd1,   // request presented, waiting for mem_addr_ok, owner locked
        WAIT = 2'd2    // request accepted, waiting for mem_data_ok
    } arb_state_t;

    typedef enum logic {
        OWN_DATA = 1'b0,
        OWN_INST = 1'b1
    } owner_t;

endpackage

// File: rtl/sram_like_mux2.sv
// Steers the granted master's request fields onto the shared port and routes addr_ok/data_ok back to it only.
// Latency: purely combinational, zero cycles.
// Backpressure: none of its own; mem_req is the granted master's req qualified by fwd.
// Ports: grant (OWN_INST/OWN_DATA), fwd (request forwarding enable), inst_*/data_* request fields,
//        addr_ok/data_ok (handshakes already qualified by the FSM), mem_* request fields, per-master oks.
module sram_like_mux2
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              grant,
    input  logic              fwd,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic              data_addr_ok,
    output logic              data_data_ok
);

    logic pick_inst;
    assign pick_inst = (grant == OWN_INST);

    assign mem_req   = fwd & (pick_inst ? inst_req : data_req);
    assign mem_wr    = pick_inst ? inst_wr    : data_wr;
    assign mem_size  = pick_inst ? inst_size  : data_size;
    assign mem_addr  = pick_inst ? inst_addr  : data_addr;
    assign mem_wdata = pick_inst ? inst_wdata : data_wdata;

    // The non-granted master never sees a handshake.
    assign inst_addr_ok = addr_ok &  pick_inst;
    assign data_addr_ok = addr_ok & ~pick_inst;
    assign inst_data_ok = data_ok &  pick_inst;
    assign data_data_ok = data_ok & ~pick_inst;

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram_like port between fetch and MEM-stage masters; data wins unless fetch has starved STARVE_LIMIT grants.
// Latency: zero added cycles on the request path (IDLE forwards combinationally); one transaction outstanding.
// Backpressure: mem_addr_ok low locks the chosen owner in ADDR; masters hold req until their addr_ok.
// Ports: clk/resetn, inst_* and data_* sram_like slave ports toward the core, mem_* master port toward the bridge.
module sram_like_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state, state_nxt;
    owner_t           owner, owner_nxt, grant, sel;
    logic [CNT_W-1:0] starve_cnt;
    logic             owner_req;
    logic             fwd_c, aok_c, dok_c;
    logic             fwd, addr_hs, data_hs;

    // Fetch only wins a contested cycle once it has watched STARVE_LIMIT data grants go by.
    assign sel       = (inst_req && (!data_req || starve_cnt == CNT_MAX)) ? OWN_INST : OWN_DATA;
    assign owner_req = (owner == OWN_INST) ? inst_req : data_req;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        grant     = owner;
        fwd_c     = 1'b0;
        aok_c     = 1'b0;
        dok_c     = 1'b0;
        case (state)
            IDLE: begin
                grant = sel;
                fwd_c = 1'b1;
                if (inst_req || data_req) begin
                    owner_nxt = sel;
                    if (mem_addr_ok) begin
                        aok_c     = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = ADDR;
                    end
                end
            end
            ADDR: begin
                fwd_c = 1'b1;
                // A master withdrawing its request is a protocol error; abandon quietly.
                if (!owner_req) begin
                    state_nxt = IDLE;
                end else if (mem_addr_ok) begin
                    aok_c     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_data_ok) begin
                    dok_c     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Keep the bus and both masters quiet while reset is held, even with requests present.
    assign fwd     = fwd_c & resetn;
    assign addr_hs = aok_c & resetn;
    assign data_hs = dok_c & resetn;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            owner <= OWN_DATA;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (addr_hs && grant == OWN_DATA && inst_req) begin
            if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else if ((addr_hs && grant == OWN_INST) || !inst_req) begin
            starve_cnt <= '0;
        end
    end

    sram_like_mux2 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .grant        (grant),
        .fwd          (fwd),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .addr_ok      (addr_hs),
        .data_ok      (data_hs),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok)
    );

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized and directed stimulus for sram_like_arbiter against a transaction-level arbitration model.
// Latency: n/a.
// Backpressure: the bench slave withholds addr_ok randomly and delays data_ok by 0..lat_max cycles.
module tb_sram_like_arbiter;
    import cpu_bus_pkg::*;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, mem_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata, mem_rdata, mem_addr, mem_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;

    always #5 clk = ~clk;

    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Slave memory contents: one fixed boot word, everything else a scramble of the address.
    function automatic logic [31:0] rd_of(logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2408_0001;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    typedef struct packed {
        logic        who;     // 1 = fetch, 0 = data
        logic [31:0] rdata;
    } resp_t;
    resp_t exp_q[$];

    // ---------------- reference model: bus free/busy, grant rule, starvation count ----------------
    logic m_free = 1'b1, m_lock = 1'b0, m_wait = 1'b0, m_win = 1'b0;
    int   m_cnt  = 0;

    always @(negedge clk) begin : model
        logic        exp_ia, exp_da, dok_seen;
        logic [66:0] wf;
        if (!resetn) begin
            m_free = 1'b1; m_lock = 1'b0; m_wait = 1'b0; m_cnt = 0;
            exp_q.delete();
            check("rst_mem_req", mem_req, 0);
            check("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        end else begin
            exp_ia   = 1'b0;
            exp_da   = 1'b0;
            dok_seen = m_wait && mem_data_ok;
            if (m_free && (inst_req || data_req)) begin
                m_win  = inst_req && (!data_req || m_cnt == LIM);
                m_free = 1'b0;
                m_lock = 1'b1;
            end
            if (m_lock) begin
                check("mem_req_on", mem_req, 1);
                wf = m_win ? {inst_wr, inst_size, inst_addr, inst_wdata} : {data_wr, data_size, data_addr, data_wdata};
                check("mem_fields", {mem_wr, mem_size, mem_addr, mem_wdata}, wf);
                if (mem_addr_ok) begin
                    exp_ia = m_win;
                    exp_da = !m_win;
                    exp_q.push_back('{who: m_win, rdata: rd_of(m_win ? inst_addr : data_addr)});
                    if (m_win) m_cnt = 0;
                    else if (inst_req) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
                    m_lock = 1'b0;
                    m_wait = 1'b1;
                end
            end else begin
                check("mem_req_off", mem_req, 0);
            end
            check("inst_addr_ok", inst_addr_ok, exp_ia);
            check("data_addr_ok", data_addr_ok, exp_da);
            if (!inst_req) m_cnt = 0;
            if (dok_seen) begin
                m_wait = 1'b0;
                m_free = 1'b1;
            end
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge clk) begin : monitor
        resp_t e;
        if (resetn) begin
            check("rdata_bcast", {inst_rdata, data_rdata}, {mem_rdata, mem_rdata});
            if (inst_data_ok || data_data_ok) begin
                check("single_data_ok", inst_data_ok & data_data_ok, 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_data_ok: inst=%0b data=%0b expected none (t=%0t)",
                             inst_data_ok, data_data_ok, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_owner", inst_data_ok, e.who);
                    check("resp_rdata", e.who ? inst_rdata : data_rdata, e.rdata);
                end
            end
        end
    end

    // ---------------- stimulus: two masters and a slave ----------------
    int   i_todo = 0, d_todo = 0, i_pct = 0, d_pct = 0;
    int   aok_pct = 0, lat_max = 0, stray_pct = 0;
    int   s_cnt = 0;
    logic s_busy = 1'b0;
    logic [31:0] s_addr = '0;
    logic i_aok_seen = 1'b0, i_out = 1'b0, d_aok_seen = 1'b0, d_out = 1'b0;
    logic obs_ia, obs_id, obs_da, obs_dd;
    logic [31:0] obs_irdata;

    task automatic drive();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = $urandom();
        if (s_busy) begin
            if (s_cnt == 0) begin
                mem_data_ok = 1'b1;
                mem_rdata   = rd_of(s_addr);
            end else begin
                s_cnt--;
            end
        end else if ($urandom_range(0, 99) < aok_pct) begin
            mem_addr_ok = 1'b1;
        end else if ($urandom_range(0, 99) < stray_pct) begin
            mem_data_ok = 1'b1;
        end
        if (i_aok_seen) begin inst_req = 1'b0; i_aok_seen = 1'b0; end
        if (!inst_req && !i_out && i_todo > 0 && $urandom_range(0, 99) < i_pct) begin
            inst_req = 1'b1; inst_wr = 1'b0; inst_size = SIZE_WORD;
            inst_addr = $urandom() & 32'hFFFF_FFFC; inst_wdata = $urandom();
            i_todo--;
        end
        if (d_aok_seen) begin data_req = 1'b0; d_aok_seen = 1'b0; end
        if (!data_req && !d_out && d_todo > 0 && $urandom_range(0, 99) < d_pct) begin
            data_req = 1'b1; data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
            data_addr = $urandom(); data_wdata = $urandom();
            d_todo--;
        end
    endtask

    task automatic observe();
        obs_ia = inst_addr_ok; obs_id = inst_data_ok;
        obs_da = data_addr_ok; obs_dd = data_data_ok;
        obs_irdata = inst_rdata;
        if (inst_addr_ok) begin i_aok_seen = 1'b1; i_out = 1'b1; end
        if (inst_data_ok) i_out = 1'b0;
        if (data_addr_ok) begin d_aok_seen = 1'b1; d_out = 1'b1; end
        if (data_data_ok) d_out = 1'b0;
        if (s_busy && mem_data_ok) s_busy = 1'b0;
        else if (mem_req && mem_addr_ok) begin
            s_busy = 1'b1; s_addr = mem_addr; s_cnt = $urandom_range(0, lat_max);
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(string name, int max);
        int k = 0;
        while ((i_todo > 0 || d_todo > 0 || inst_req || data_req || i_out || d_out || s_busy) && k < max) begin
            cycle();
            k++;
        end
        check(name, k < max, 1);
    endtask

    task automatic count_data_before_inst(string name);
        int  nd  = 0;
        logic got = 1'b0;
        for (int k = 0; k < 80 && !got; k++) begin
            cycle();
            if (obs_ia) got = 1'b1;
            else if (obs_da) nd++;
        end
        check({name, "_inst_granted"}, got, 1);
        check({name, "_data_grants"}, nd, LIM);
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 0; inst_wr = 0; inst_size = SIZE_WORD; inst_addr = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = SIZE_WORD; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
        @(posedge clk); #1;
        repeat (3) cycle();
        resetn = 1'b1;
        cycle();

        // T1: single store from the data side, accepted at once, answered next cycle
        aok_pct = 100; lat_max = 0;
        data_req = 1; data_wr = 1; data_size = SIZE_WORD; data_addr = 32'h0000_1004; data_wdata = 32'hCAFE_F00D;
        cycle();
        check("t1_addr_ok", {obs_ia, obs_da}, 2'b01);
        cycle();
        check("t1_data_ok", {obs_id, obs_dd}, 2'b01);
        run_until_idle("t1_done", 20);

        // T2: simultaneous requests, data first, fetch in the next IDLE
        inst_req = 1; inst_wr = 0; inst_size = SIZE_WORD; inst_addr = 32'h0000_2000; inst_wdata = '0;
        data_req = 1; data_wr = 0; data_size = SIZE_HALF; data_addr = 32'h0000_3002; data_wdata = '0;
        cycle();
        check("t2_data_first", {obs_ia, obs_da}, 2'b01);
        cycle();
        check("t2_data_resp", {obs_id, obs_dd}, 2'b01);
        cycle();
        check("t2_inst_next", {obs_ia, obs_da}, 2'b10);
        run_until_idle("t2_done", 20);

        // T4: owner locked while addr_ok is withheld and the other master arrives
        aok_pct = 0;
        inst_req = 1; inst_addr = 32'h0000_4000;
        cycle();
        data_req = 1; data_wr = 1; data_size = SIZE_BYTE; data_addr = 32'h0000_5001; data_wdata = 32'h0000_00AB;
        repeat (3) cycle();
        check("t4_locked_addr", mem_addr, 32'h0000_4000);
        aok_pct = 100;
        cycle();
        check("t4_inst_wins", {obs_ia, obs_da}, 2'b10);
        run_until_idle("t4_done", 20);

        // T6: boot fetch read data
        inst_req = 1; inst_wr = 0; inst_size = SIZE_WORD; inst_addr = 32'hBFC0_0000;
        cycle();
        cycle();
        check("t6_oks", {obs_id, obs_dd}, 2'b10);
        check("t6_rdata", obs_irdata, 32'h2408_0001);
        run_until_idle("t6_done", 20);

        // T3: continuous data traffic, fetch held; fetch must be forced in after LIM data grants, twice
        d_todo = 1000; d_pct = 100;
        inst_req = 1; inst_addr = 32'h0000_6000;
        count_data_before_inst("t3_round1");
        repeat (3) cycle();
        inst_req = 1; inst_addr = 32'h0000_6100;
        count_data_before_inst("t3_round2");
        d_todo = 0;
        run_until_idle("t3_done", 40);

        // T5: reset during WAIT, stray data_ok afterwards
        data_req = 1; data_wr = 0; data_size = SIZE_WORD; data_addr = 32'h0000_7000;
        cycle();
        s_cnt = 50;
        cycle();
        resetn = 1'b0;
        s_busy = 0; i_aok_seen = 0; d_aok_seen = 0; i_out = 0; d_out = 0;
        inst_req = 1; data_req = 1;
        repeat (2) cycle();
        inst_req = 0; data_req = 0; d_aok_seen = 0; i_aok_seen = 0; s_busy = 0;
        aok_pct = 0; stray_pct = 100;
        resetn = 1'b1;
        cycle();
        check("t5_stray1", {obs_id, obs_dd}, 2'b00);
        cycle();
        check("t5_stray2", {obs_id, obs_dd}, 2'b00);
        stray_pct = 0; aok_pct = 100;
        data_req = 1; data_addr = 32'h0000_7100;
        cycle();
        check("t5_new_grant", {obs_ia, obs_da}, 2'b01);
        run_until_idle("t5_done", 20);

        // Random traffic: stalls, variable latency, occasional stray data_ok
        i_todo = 50; d_todo = 80; i_pct = 40; d_pct = 50;
        aok_pct = 60; lat_max = 3; stray_pct = 10;
        run_until_idle("rand1_done", 4000);

        // Random traffic biased to contention so starvation forcing appears naturally
        i_todo = 30; d_todo = 90; i_pct = 70; d_pct = 95;
        aok_pct = 100; lat_max = 1; stray_pct = 0;
        run_until_idle("rand2_done", 4000);

        repeat (3) cycle();
        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
